// File: rtl/norm_row_packer.sv
// Packs serial normalized words into COL-word rows and writes them to SRAM via a one-row hold buffer.
// Row write is requested the cycle after its last word; the hold buffer absorbs up to COL-1 cycles of mem_ready low.
module norm_row_packer #(
    parameter int BW_PSUM = 11,
    parameter int COL     = 8,
    parameter int ROWS    = 16,
    parameter int ADDR_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     norm_valid,
    input  logic [BW_PSUM-1:0]       psum_norm,
    input  logic                     mem_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [BW_PSUM*COL-1:0]   wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int DW = BW_PSUM * COL;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam logic [CW-1:0]     K_LAST    = CW'(COL - 1);
    localparam logic [RW-1:0]     ROWS_FULL = RW'(ROWS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     k_q;
    logic [RW-1:0]     rows_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              ovf_q;
    logic [DW-1:0]     pack_q;
    logic [DW-1:0]     hold_q;
    logic [DW-1:0]     pack_d;

    // Pack register with the current word merged in, so a completing row carries its last word.
    always_comb begin
        pack_d = pack_q;
        pack_d[k_q*BW_PSUM +: BW_PSUM] = psum_norm;
    end

    assign wr_en    = pend_q & mem_ready;
    assign wr_addr  = addr_q;
    assign wr_data  = hold_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            rows_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pack_q  <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (wr_en) begin
                        pend_q <= 1'b0;
                        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
                        if (addr_q == ADDR_LAST) begin
                            state_q <= S_DONE;
                        end
                    end
                    if (norm_valid) begin
                        if (rows_q == ROWS_FULL) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pack_q <= pack_d;
                            if (k_q == K_LAST) begin
                                k_q <= '0;
                                // A write-out on this edge frees the buffer in time for the reload.
                                if (!pend_q || wr_en) begin
                                    hold_q <= pack_d;
                                    pend_q <= 1'b1;
                                    rows_q <= rows_q + RW'(1);
                                end else begin
                                    ovf_q <= 1'b1;
                                end
                            end else begin
                                k_q <= k_q + CW'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= S_RUN;
                        k_q     <= '0;
                        rows_q  <= '0;
                        addr_q  <= '0;
                        pend_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/norm_row_packer.md
# norm_row_packer

Downstream stage of the normalizer. Collects the serial stream of normalized partial sums (one `BW_PSUM`-bit word per `norm_valid` cycle) into full rows of `COL` words. Writes each completed row, with an incrementing address, into the output SRAM through a single-entry hold buffer. Absorbs short SRAM back-pressure, because the normalizer has no ready input.

## Interface
Parameters:
- `BW_PSUM`, 11, width of one normalized word
- `COL`, 8, words per packed row
- `ROWS`, 16, rows per run (one write burst)
- `ADDR_W`, 4, SRAM address width; ceil(log2(`ROWS`)), minimum 1

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  single-cycle pulse; begins a run of `ROWS` rows
- `norm_valid`  in  1  `psum_norm` is valid this cycle
- `psum_norm`  in  `BW_PSUM`  normalized word from normalizer
- `mem_ready`  in  1  SRAM accepts a write this cycle
- `wr_en`  out  1  row write strobe
- `wr_addr`  out  `ADDR_W`  row address
- `wr_data`  out  `BW_PSUM*COL`  packed row
- `busy`  out  1  run in progress
- `done`  out  1  all `ROWS` rows written (level, held until next `start`)
- `overflow`  out  1  sticky: a word or row was dropped this run

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE→RUN on `start`.
  - RUN→DONE on the edge where `wr_en` is high and `wr_addr==ROWS-1`.
  - DONE→RUN on `start`.
  - `start` in RUN is ignored.
- Entering RUN clears:
  - the word counter (0..`COL-1`)
  - the rows-packed counter (0..`ROWS`)
  - `wr_addr`
  - the pending flag
  - `overflow`
  - `done`
- Packing, in RUN only:
  - Each `norm_valid` writes `psum_norm` into slice [k*BW_PSUM +: BW_PSUM] of the pack register, where k is the word counter.
  - The first word lands in the LSB slice.
  - The word counter increments and wraps at `COL`.
- Row completion is the `norm_valid` cycle with k==`COL-1`. On that edge:
  - If the hold buffer is free, or is being written out this same cycle: load the pack register, including the current word, into the hold register; set pending; increment rows-packed.
  - Otherwise: drop the row and set `overflow`. Rows-packed does not increment.
  - The word counter returns to 0 in both cases.
- Once rows-packed==`ROWS`, further `norm_valid` words in RUN are dropped and set `overflow`.
- `norm_valid` is ignored in IDLE and DONE. `overflow` does not change outside RUN.
- Write-out:
  - `wr_en` = pending & `mem_ready` (combinational from registered pending).
  - `wr_data` = hold register.
  - At the edge where `wr_en` is high: clear pending, unless reloaded the same edge; increment `wr_addr`, wrapping to 0 after `ROWS-1`.
- Arithmetic: pure bit packing, no sign or width change. `wr_data` is unchanged while pending and `mem_ready` is low.
- `busy` = (state==RUN). `done` = (state==DONE).

## Timing
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `overflow`=0
  - internal counters, pack register and pending are 0
- Reset mid-run discards all partial and pending data immediately; no write is issued.
- Latency: the `COL`-th word is sampled at edge N. Pending is set at N. `wr_en` is high in cycle N+1 if `mem_ready` is high.
- Sustained throughput: one row per `COL` cycles with `mem_ready` tied high. Zero words are lost with `norm_valid` high every cycle.
- Back-pressure tolerance: `mem_ready` may stay low for up to `COL-1` cycles after pending is set without loss.
- Simultaneous events:
  - Row completion on the same edge as a write-out reloads the hold buffer; pending stays 1.
  - `start` on the same cycle as `norm_valid`: that word is ignored, because the state is still IDLE/DONE.
- `done` rises the cycle after the final write. `busy` falls in the same cycle.

## Test plan
- Reset/idle:
  - Assert `reset` mid-stream → all outputs 0 the same cycle.
  - After release, `norm_valid` pulses without `start` → no `wr_en`, `overflow`=0.
- Basic packing (`COL`=8, `mem_ready`=1):
  - `start`, then 8 consecutive words 1..8 → `wr_en` for one cycle, 1 cycle after word 8.
  - `wr_addr`=0; `wr_data` slice0=1 … slice7=8.
- Full run:
  - `ROWS`=16 rows streamed back-to-back, word value = row*8+col → 16 writes, addresses 0..15, no gaps beyond 7 idle cycles.
  - `done`=1 and `busy`=0 the cycle after the write to address 15.
- Back-pressure:
  - `mem_ready` low for 7 cycles after row 0 completes while row 1 streams → row 0 written intact, row 1 intact, `overflow`=0.
  - Repeat with `mem_ready` held low for 9 cycles → row 1 dropped, `overflow`=1, row 0 still written once.
- Excess and restart:
  - Send 17 rows → 16 writes, `overflow`=1 after the first word of row 17.
  - `start` in DONE → `overflow`=0, `done`=0, `wr_addr`=0, next row written at address 0.
- Start in RUN:
  - Pulse `start` after 3 words of a row → ignored; the row completes normally with those 3 words in slices 0..2.
